axi4_burst_split: RTL and testbench

Upstream companion to the AXI4-to-PI1 bridge. Accepts full AXI4 bursts (FIXED/INCR/WRAP, len 0..255) from a master. Replays each burst as a sequence of single-beat AXI4 transactions on its master port, which connects directly to the bridge's slave port. It never drives read and write address valids together, one beat outstanding at a time.

---
 rtl/axi4_burst_split.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_axi4_burst_split.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_split.sv
// Replays AXI4 bursts from the slave port as single-beat AXI4 transactions on the master port,
// one beat outstanding at a time, with write responses merged into one burst response.
module axi4_burst_split #(
    parameter int unsigned ARCHBITSZ     = 32,
    parameter int unsigned AXI4_ID_WIDTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,

    input  logic [AXI4_ID_WIDTH-1:0] s_axi4_awid_i,
    input  logic [ARCHBITSZ-1:0]     s_axi4_awaddr_i,
    input  logic [7:0]               s_axi4_awlen_i,
    input  logic [2:0]               s_axi4_awsize_i,
    input  logic [1:0]               s_axi4_awburst_i,
    input  logic                     s_axi4_awlock_i,
    input  logic [3:0]               s_axi4_awcache_i,
    input  logic [2:0]               s_axi4_awprot_i,
    input  logic [3:0]               s_axi4_awqos_i,
    input  logic                     s_axi4_awvalid_i,
    output logic                     s_axi4_awready_o,
    input  logic [ARCHBITSZ-1:0]     s_axi4_wdata_i,
    input  logic [ARCHBITSZ/8-1:0]   s_axi4_wstrb_i,
    input  logic                     s_axi4_wlast_i,
    input  logic                     s_axi4_wvalid_i,
    output logic                     s_axi4_wready_o,
    output logic [AXI4_ID_WIDTH-1:0] s_axi4_bid_o,
    output logic [1:0]               s_axi4_bresp_o,
    output logic                     s_axi4_bvalid_o,
    input  logic                     s_axi4_bready_i,
    input  logic [AXI4_ID_WIDTH-1:0] s_axi4_arid_i,
    input  logic [ARCHBITSZ-1:0]     s_axi4_araddr_i,
    input  logic [7:0]               s_axi4_arlen_i,
    input  logic [2:0]               s_axi4_arsize_i,
    input  logic [1:0]               s_axi4_arburst_i,
    input  logic                     s_axi4_arlock_i,
    input  logic [3:0]               s_axi4_arcache_i,
    input  logic [2:0]               s_axi4_arprot_i,
    input  logic [3:0]               s_axi4_arqos_i,
    input  logic                     s_axi4_arvalid_i,
    output logic                     s_axi4_arready_o,
    output logic [AXI4_ID_WIDTH-1:0] s_axi4_rid_o,
    output logic [ARCHBITSZ-1:0]     s_axi4_rdata_o,
    output logic [1:0]               s_axi4_rresp_o,
    output logic                     s_axi4_rlast_o,
    output logic                     s_axi4_rvalid_o,
    input  logic                     s_axi4_rready_i,

    output logic [AXI4_ID_WIDTH-1:0] m_axi4_awid_o,
    output logic [ARCHBITSZ-1:0]     m_axi4_awaddr_o,
    output logic [7:0]               m_axi4_awlen_o,
    output logic [2:0]               m_axi4_awsize_o,
    output logic [1:0]               m_axi4_awburst_o,
    output logic                     m_axi4_awlock_o,
    output logic [3:0]               m_axi4_awcache_o,
    output logic [2:0]               m_axi4_awprot_o,
    output logic [3:0]               m_axi4_awqos_o,
    output logic                     m_axi4_awvalid_o,
    input  logic                     m_axi4_awready_i,
    output logic [ARCHBITSZ-1:0]     m_axi4_wdata_o,
    output logic [ARCHBITSZ/8-1:0]   m_axi4_wstrb_o,
    output logic                     m_axi4_wlast_o,
    output logic                     m_axi4_wvalid_o,
    input  logic                     m_axi4_wready_i,
    input  logic [AXI4_ID_WIDTH-1:0] m_axi4_bid_i,
    input  logic [1:0]               m_axi4_bresp_i,
    input  logic                     m_axi4_bvalid_i,
    output logic                     m_axi4_bready_o,
    output logic [AXI4_ID_WIDTH-1:0] m_axi4_arid_o,
    output logic [ARCHBITSZ-1:0]     m_axi4_araddr_o,
    output logic [7:0]               m_axi4_arlen_o,
    output logic [2:0]               m_axi4_arsize_o,
    output logic [1:0]               m_axi4_arburst_o,
    output logic                     m_axi4_arlock_o,
    output logic [3:0]               m_axi4_arcache_o,
    output logic [2:0]               m_axi4_arprot_o,
    output logic [3:0]               m_axi4_arqos_o,
    output logic                     m_axi4_arvalid_o,
    input  logic                     m_axi4_arready_i,
    input  logic [AXI4_ID_WIDTH-1:0] m_axi4_rid_i,
    input  logic [ARCHBITSZ-1:0]     m_axi4_rdata_i,
    input  logic [1:0]               m_axi4_rresp_i,
    input  logic                     m_axi4_rlast_i,
    input  logic                     m_axi4_rvalid_i,
    output logic                     m_axi4_rready_o
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, RADDR, RDATA, RHOLD, WADDR, WRESP, BRESP} state_t;

    state_t                   state_q, state_d;
    logic [AXI4_ID_WIDTH-1:0] id_q;
    logic [ARCHBITSZ-1:0]     addr_q;
    logic [7:0]               len_q, cnt_q;
    logic [2:0]               size_q;
    logic [1:0]               burst_q;
    logic                     lock_q;
    logic [3:0]               cache_q, qos_q;
    logic [2:0]               prot_q;
    logic                     last_wr_q;
    logic [ARCHBITSZ-1:0]     hold_data_q;
    logic [1:0]               hold_resp_q, wacc_q;

    logic                     pick_rd, pick_wr, is_last, w_xfer;
    logic [ARCHBITSZ-1:0]     step, aligned, wmask, next_addr;

    // Response IDs and last flags from the bridge carry no information for single beats.
    logic unused_c;
    assign unused_c = ^{m_axi4_bid_i, m_axi4_rid_i, m_axi4_rlast_i};

    assign is_last = (cnt_q == len_q);
    assign pick_rd = s_axi4_arvalid_i & (~s_axi4_awvalid_i | last_wr_q);
    assign pick_wr = s_axi4_awvalid_i & ~pick_rd;
    assign w_xfer  = s_axi4_wvalid_i & m_axi4_awready_i & m_axi4_wready_i;

    // Next beat address; reserved burst type falls into the INCR arm.
    always_comb begin
        step    = ARCHBITSZ'(1) << size_q;
        aligned = addr_q & ~(step - ARCHBITSZ'(1));
        wmask   = ((ARCHBITSZ'(len_q) + ARCHBITSZ'(1)) << size_q) - ARCHBITSZ'(1);
        case (burst_q)
            2'b00:   next_addr = addr_q;
            2'b10:   next_addr = (addr_q & ~wmask) | ((aligned + step) & wmask);
            default: next_addr = aligned + step;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d          = state_q;
        s_axi4_awready_o = 1'b0;
        s_axi4_arready_o = 1'b0;
        s_axi4_wready_o  = 1'b0;
        s_axi4_bvalid_o  = 1'b0;
        s_axi4_rvalid_o  = 1'b0;
        s_axi4_rlast_o   = 1'b0;
        m_axi4_awvalid_o = 1'b0;
        m_axi4_wvalid_o  = 1'b0;
        m_axi4_bready_o  = 1'b0;
        m_axi4_arvalid_o = 1'b0;
        m_axi4_rready_o  = 1'b0;
        m_axi4_wdata_o   = '0;
        m_axi4_wstrb_o   = '0;
        case (state_q)
            IDLE: begin
                s_axi4_arready_o = pick_rd;
                s_axi4_awready_o = pick_wr;
                if (pick_rd)      state_d = RADDR;
                else if (pick_wr) state_d = WADDR;
            end
            RADDR: begin
                m_axi4_arvalid_o = 1'b1;
                m_axi4_rready_o  = 1'b1;
                if (m_axi4_arready_i) state_d = RDATA;
            end
            RDATA: begin
                m_axi4_rready_o = 1'b1;
                if (m_axi4_rvalid_i) state_d = RHOLD;
            end
            RHOLD: begin
                s_axi4_rvalid_o = 1'b1;
                s_axi4_rlast_o  = is_last;
                if (s_axi4_rready_i) state_d = is_last ? IDLE : RADDR;
            end
            WADDR: begin
                m_axi4_awvalid_o = s_axi4_wvalid_i;
                m_axi4_wvalid_o  = s_axi4_wvalid_i;
                m_axi4_bready_o  = 1'b1;
                m_axi4_wdata_o   = s_axi4_wdata_i;
                m_axi4_wstrb_o   = s_axi4_wstrb_i;
                s_axi4_wready_o  = m_axi4_wready_i & m_axi4_awready_i;
                if (w_xfer) state_d = WRESP;
            end
            WRESP: begin
                m_axi4_bready_o = 1'b1;
                if (m_axi4_bvalid_i) state_d = is_last ? BRESP : WADDR;
            end
            BRESP: begin
                s_axi4_bvalid_o = 1'b1;
                if (s_axi4_bready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Burst context, beat counter, read hold register and write response accumulator.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            lock_q      <= 1'b0;
            cache_q     <= '0;
            prot_q      <= '0;
            qos_q       <= '0;
            last_wr_q   <= 1'b1;
            hold_data_q <= '0;
            hold_resp_q <= RESP_OKAY;
            wacc_q      <= RESP_OKAY;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q  <= '0;
                    wacc_q <= RESP_OKAY;
                    if (pick_rd) begin
                        last_wr_q <= 1'b0;
                        id_q      <= s_axi4_arid_i;
                        addr_q    <= s_axi4_araddr_i;
                        len_q     <= s_axi4_arlen_i;
                        size_q    <= s_axi4_arsize_i;
                        burst_q   <= s_axi4_arburst_i;
                        lock_q    <= s_axi4_arlock_i;
                        cache_q   <= s_axi4_arcache_i;
                        prot_q    <= s_axi4_arprot_i;
                        qos_q     <= s_axi4_arqos_i;
                    end else if (pick_wr) begin
                        last_wr_q <= 1'b1;
                        id_q      <= s_axi4_awid_i;
                        addr_q    <= s_axi4_awaddr_i;
                        len_q     <= s_axi4_awlen_i;
                        size_q    <= s_axi4_awsize_i;
                        burst_q   <= s_axi4_awburst_i;
                        lock_q    <= s_axi4_awlock_i;
                        cache_q   <= s_axi4_awcache_i;
                        prot_q    <= s_axi4_awprot_i;
                        qos_q     <= s_axi4_awqos_i;
                    end
                end
                RDATA: begin
                    if (m_axi4_rvalid_i) begin
                        hold_data_q <= m_axi4_rdata_i;
                        hold_resp_q <= m_axi4_rresp_i;
                    end
                end
                RHOLD: begin
                    if (s_axi4_rready_i && !is_last) begin
                        cnt_q  <= cnt_q + 8'd1;
                        addr_q <= next_addr;
                    end
                end
                WADDR: begin
                    // A misplaced wlast is a protocol error unless an earlier beat already failed.
                    if (w_xfer && (s_axi4_wlast_i != is_last) && !wacc_q[1])
                        wacc_q <= RESP_SLVERR;
                end
                WRESP: begin
                    if (m_axi4_bvalid_i) begin
                        if (!wacc_q[1]) begin
                            if (m_axi4_bresp_i[1])
                                wacc_q <= m_axi4_bresp_i;
                            else if (m_axi4_bresp_i == RESP_EXOKAY && len_q == 8'd0)
                                wacc_q <= RESP_EXOKAY;
                        end
                        if (!is_last) begin
                            cnt_q  <= cnt_q + 8'd1;
                            addr_q <= next_addr;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_axi4_bid_o     = id_q;
    assign s_axi4_bresp_o   = wacc_q;
    assign s_axi4_rid_o     = id_q;
    assign s_axi4_rdata_o   = hold_data_q;
    assign s_axi4_rresp_o   = hold_resp_q;

    assign m_axi4_awid_o    = id_q;
    assign m_axi4_awaddr_o  = addr_q;
    assign m_axi4_awlen_o   = 8'd0;
    assign m_axi4_awsize_o  = size_q;
    assign m_axi4_awburst_o = 2'b01;
    assign m_axi4_awlock_o  = lock_q & (len_q == 8'd0);
    assign m_axi4_awcache_o = cache_q;
    assign m_axi4_awprot_o  = prot_q;
    assign m_axi4_awqos_o   = qos_q;
    assign m_axi4_wlast_o   = 1'b1;

    assign m_axi4_arid_o    = id_q;
    assign m_axi4_araddr_o  = addr_q;
    assign m_axi4_arlen_o   = 8'd0;
    assign m_axi4_arsize_o  = size_q;
    assign m_axi4_arburst_o = 2'b01;
    assign m_axi4_arlock_o  = lock_q & (len_q == 8'd0);
    assign m_axi4_arcache_o = cache_q;
    assign m_axi4_arprot_o  = prot_q;
    assign m_axi4_arqos_o   = qos_q;

endmodule

// File: tb/tb_axi4_burst_split.sv
// Scoreboard bench for axi4_burst_split: directed bursts push expected beats, a monitor
// compares every handshake, and a small downstream slave model answers single beats.
module tb_axi4_burst_split;

    logic        clk_i = 1'b0;
    logic        rst_i;
    always #5 clk_i = ~clk_i;

    logic [3:0]  s_awid, s_arid, s_bid, s_rid, m_awid, m_arid, m_bid, m_rid;
    logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata, m_awaddr, m_araddr, m_wdata, m_rdata;
    logic [7:0]  s_awlen, s_arlen, m_awlen, m_arlen;
    logic [2:0]  s_awsize, s_arsize, m_awsize, m_arsize, s_awprot, s_arprot, m_awprot, m_arprot;
    logic [1:0]  s_awburst, s_arburst, m_awburst, m_arburst, s_bresp, s_rresp, m_bresp, m_rresp;
    logic        s_awlock, s_arlock, m_awlock, m_arlock;
    logic [3:0]  s_awcache, s_arcache, m_awcache, m_arcache, s_awqos, s_arqos, m_awqos, m_arqos;
    logic [3:0]  s_wstrb, m_wstrb;
    logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
    logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;

    axi4_burst_split #(.ARCHBITSZ(32), .AXI4_ID_WIDTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s_axi4_awid_i(s_awid), .s_axi4_awaddr_i(s_awaddr), .s_axi4_awlen_i(s_awlen),
        .s_axi4_awsize_i(s_awsize), .s_axi4_awburst_i(s_awburst), .s_axi4_awlock_i(s_awlock),
        .s_axi4_awcache_i(s_awcache), .s_axi4_awprot_i(s_awprot), .s_axi4_awqos_i(s_awqos),
        .s_axi4_awvalid_i(s_awvalid), .s_axi4_awready_o(s_awready),
        .s_axi4_wdata_i(s_wdata), .s_axi4_wstrb_i(s_wstrb), .s_axi4_wlast_i(s_wlast),
        .s_axi4_wvalid_i(s_wvalid), .s_axi4_wready_o(s_wready),
        .s_axi4_bid_o(s_bid), .s_axi4_bresp_o(s_bresp), .s_axi4_bvalid_o(s_bvalid),
        .s_axi4_bready_i(s_bready),
        .s_axi4_arid_i(s_arid), .s_axi4_araddr_i(s_araddr), .s_axi4_arlen_i(s_arlen),
        .s_axi4_arsize_i(s_arsize), .s_axi4_arburst_i(s_arburst), .s_axi4_arlock_i(s_arlock),
        .s_axi4_arcache_i(s_arcache), .s_axi4_arprot_i(s_arprot), .s_axi4_arqos_i(s_arqos),
        .s_axi4_arvalid_i(s_arvalid), .s_axi4_arready_o(s_arready),
        .s_axi4_rid_o(s_rid), .s_axi4_rdata_o(s_rdata), .s_axi4_rresp_o(s_rresp),
        .s_axi4_rlast_o(s_rlast), .s_axi4_rvalid_o(s_rvalid), .s_axi4_rready_i(s_rready),
        .m_axi4_awid_o(m_awid), .m_axi4_awaddr_o(m_awaddr), .m_axi4_awlen_o(m_awlen),
        .m_axi4_awsize_o(m_awsize), .m_axi4_awburst_o(m_awburst), .m_axi4_awlock_o(m_awlock),
        .m_axi4_awcache_o(m_awcache), .m_axi4_awprot_o(m_awprot), .m_axi4_awqos_o(m_awqos),
        .m_axi4_awvalid_o(m_awvalid), .m_axi4_awready_i(m_awready),
        .m_axi4_wdata_o(m_wdata), .m_axi4_wstrb_o(m_wstrb), .m_axi4_wlast_o(m_wlast),
        .m_axi4_wvalid_o(m_wvalid), .m_axi4_wready_i(m_wready),
        .m_axi4_bid_i(m_bid), .m_axi4_bresp_i(m_bresp), .m_axi4_bvalid_i(m_bvalid),
        .m_axi4_bready_o(m_bready),
        .m_axi4_arid_o(m_arid), .m_axi4_araddr_o(m_araddr), .m_axi4_arlen_o(m_arlen),
        .m_axi4_arsize_o(m_arsize), .m_axi4_arburst_o(m_arburst), .m_axi4_arlock_o(m_arlock),
        .m_axi4_arcache_o(m_arcache), .m_axi4_arprot_o(m_arprot), .m_axi4_arqos_o(m_arqos),
        .m_axi4_arvalid_o(m_arvalid), .m_axi4_arready_i(m_arready),
        .m_axi4_rid_i(m_rid), .m_axi4_rdata_i(m_rdata), .m_axi4_rresp_i(m_rresp),
        .m_axi4_rlast_i(m_rlast), .m_axi4_rvalid_i(m_rvalid), .m_axi4_rready_o(m_rready)
    );

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;

    bit          q_ord[$];
    logic [31:0] q_ar[$];
    logic [38:0] q_r[$];
    logic [68:0] q_aw[$];
    logic [5:0]  q_b[$];

    logic [1:0]  b_resp_k = 2'b00;
    bit          hold_r = 1'b0;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [31:0] wd(input logic [3:0] id, input int i);
        return 32'hD000_0000 | (32'(id) << 8) | 32'(i);
    endfunction

    // Downstream single-beat slave: answers one cycle after each accepted request.
    initial begin
        bit ar_f, r_f, w_f, b_f;
        logic [31:0] ar_a;
        m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
        m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00; m_rlast = 1'b1; m_rid = '0;
        m_bvalid = 1'b0; m_bresp = 2'b00; m_bid = '0;
        forever begin
            @(negedge clk_i);
            ar_f = m_arvalid & m_arready;
            ar_a = m_araddr;
            r_f  = m_rvalid & m_rready;
            w_f  = m_awvalid & m_awready & m_wvalid & m_wready;
            b_f  = m_bvalid & m_bready;
            @(posedge clk_i); #1;
            if (r_f) m_rvalid = 1'b0;
            if (b_f) m_bvalid = 1'b0;
            if (ar_f && !hold_r) begin m_rvalid = 1'b1; m_rdata = ar_a ^ 32'hA5A5_0000; end
            if (w_f) begin m_bvalid = 1'b1; m_bresp = b_resp_k; end
        end
    end

    // Monitor: pops the scoreboard on every handshake.
    initial begin
        forever begin
            @(negedge clk_i);
            if (m_arvalid || m_awvalid) chk("ar_aw_exclusive", 80'(m_arvalid & m_awvalid), 80'(0));
            if (s_arvalid && s_arready) begin
                if (q_ord.size() == 0) chk("order_unexpected_ar", 80'(1), 80'(0));
                else chk("accept_order_ar", 80'(0), 80'(q_ord.pop_front()));
            end
            if (s_awvalid && s_awready) begin
                if (q_ord.size() == 0) chk("order_unexpected_aw", 80'(1), 80'(0));
                else chk("accept_order_aw", 80'(1), 80'(q_ord.pop_front()));
            end
            if (m_arvalid && m_arready) begin
                if (q_ar.size() == 0) chk("m_ar_unexpected", 80'(m_araddr), 80'hFFFF);
                else chk("m_araddr", 80'(m_araddr), 80'(q_ar.pop_front()));
                chk("m_ar_len_burst", 80'({m_arlen, m_arburst}), 80'({8'd0, 2'b01}));
            end
            if (s_rvalid && s_rready) begin
                if (q_r.size() == 0) chk("s_r_unexpected", 80'(s_rdata), 80'hFFFF);
                else chk("s_r_beat", 80'({s_rid, s_rresp, s_rlast, s_rdata}), 80'(q_r.pop_front()));
            end
            if (m_awvalid && m_awready && m_wvalid && m_wready) begin
                if (q_aw.size() == 0) chk("m_aw_unexpected", 80'(m_awaddr), 80'hFFFF);
                else chk("m_aw_beat", 80'({m_awid, m_awlock, m_awaddr, m_wdata}), 80'(q_aw.pop_front()));
                chk("m_aw_len_burst_wlast", 80'({m_awlen, m_awburst, m_wlast}), 80'({8'd0, 2'b01, 1'b1}));
            end
            if (s_bvalid && s_bready) begin
                if (q_b.size() == 0) chk("s_b_unexpected", 80'(s_bresp), 80'hFFFF);
                else chk("s_b_resp", 80'({s_bid, s_bresp}), 80'(q_b.pop_front()));
            end
        end
    end

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [31:0] ea[4], input bit push_r);
        bit got = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            q_ar.push_back(ea[i]);
            if (push_r) q_r.push_back({id, 2'b00, 1'(i == int'(len)), ea[i] ^ 32'hA5A5_0000});
        end
        @(posedge clk_i); #1;
        s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst;
        s_arvalid = 1'b1;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk_i);
            got = s_arready;
        end
        chk("ar_accepted", 80'(got), 80'(1));
        @(posedge clk_i); #1;
        s_arvalid = 1'b0;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic lock,
                            input int bad, input logic [31:0] ea[4], input logic exp_lock,
                            input logic [1:0] exp_resp);
        bit got = 1'b0;
        for (int i = 0; i <= int'(len); i++) q_aw.push_back({id, exp_lock, ea[i], wd(id, i)});
        q_b.push_back({id, exp_resp});
        @(posedge clk_i); #1;
        s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = burst;
        s_awlock = lock; s_awvalid = 1'b1;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge clk_i);
            got = s_awready;
        end
        chk("aw_accepted", 80'(got), 80'(1));
        @(posedge clk_i); #1;
        s_awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            s_wvalid = 1'b1;
            s_wdata  = wd(id, i);
            s_wlast  = 1'(i == int'(len)) ^ 1'(i == bad);
            got = 1'b0;
            for (int t = 0; t < 100 && !got; t++) begin
                @(negedge clk_i);
                got = s_wready;
            end
            chk("w_beat_accepted", 80'(got), 80'(1));
            @(posedge clk_i); #1;
        end
        s_wvalid = 1'b0;
        s_wlast  = 1'b0;
    endtask

    task automatic wait_done();
        bit done = 1'b0;
        for (int t = 0; t < 400 && !done; t++) begin
            @(posedge clk_i);
            done = (q_ord.size() == 0) && (q_ar.size() == 0) && (q_r.size() == 0) &&
                   (q_aw.size() == 0) && (q_b.size() == 0);
        end
        chk("scoreboard_drained", 80'(done), 80'(1));
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_valids"}, 80'({s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast,
                                  m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 80'(0));
        chk({nm, "_payload"}, 80'(|{s_bid, s_bresp, s_rid, s_rdata, s_rresp, m_awid, m_arid,
                                    m_wdata, m_wstrb, m_awaddr, m_araddr}), 80'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = 3'd2; s_awburst = 2'b01; s_awlock = 1'b0;
        s_awcache = 4'h3; s_awprot = 3'd0; s_awqos = 4'd0; s_awvalid = 1'b0;
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = 3'd2; s_arburst = 2'b01; s_arlock = 1'b0;
        s_arcache = 4'h3; s_arprot = 3'd0; s_arqos = 4'd0; s_arvalid = 1'b0;
        s_wdata = '0; s_wstrb = 4'hF; s_wlast = 1'b0; s_wvalid = 1'b0;
        s_bready = 1'b1; s_rready = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk_reset_outputs("reset");
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Simultaneous AR/AW right after reset: read wins.
        q_ord.push_back(1'b0); q_ord.push_back(1'b1);
        fork
            do_read(4'd2, 32'h500, 8'd0, 3'd2, 2'b01, '{32'h500, 32'h0, 32'h0, 32'h0}, 1'b1);
            do_write(4'd3, 32'h600, 8'd0, 3'd2, 2'b01, 1'b0, -1, '{32'h600, 32'h0, 32'h0, 32'h0}, 1'b0, 2'b00);
        join
        wait_done();

        q_ord.push_back(1'b0);
        do_read(4'd1, 32'h100, 8'd3, 3'd2, 2'b01, '{32'h100, 32'h104, 32'h108, 32'h10C}, 1'b1);
        wait_done();
        q_ord.push_back(1'b0);
        do_read(4'd5, 32'h108, 8'd3, 3'd2, 2'b10, '{32'h108, 32'h10C, 32'h100, 32'h104}, 1'b1);
        wait_done();
        q_ord.push_back(1'b0);
        do_read(4'd6, 32'h101, 8'd1, 3'd2, 2'b01, '{32'h101, 32'h104, 32'h0, 32'h0}, 1'b1);
        wait_done();
        q_ord.push_back(1'b0);
        do_read(4'd7, 32'h40, 8'd2, 3'd2, 2'b00, '{32'h40, 32'h40, 32'h40, 32'h0}, 1'b1);
        wait_done();

        q_ord.push_back(1'b1);
        do_write(4'd4, 32'h200, 8'd1, 3'd2, 2'b01, 1'b0, -1, '{32'h200, 32'h204, 32'h0, 32'h0}, 1'b0, 2'b00);
        wait_done();
        q_ord.push_back(1'b1);
        do_write(4'd4, 32'h200, 8'd1, 3'd2, 2'b01, 1'b0, 0, '{32'h200, 32'h204, 32'h0, 32'h0}, 1'b0, 2'b10);
        wait_done();
        q_ord.push_back(1'b1);
        do_write(4'd4, 32'h200, 8'd1, 3'd2, 2'b01, 1'b0, 1, '{32'h200, 32'h204, 32'h0, 32'h0}, 1'b0, 2'b10);
        wait_done();

        b_resp_k = 2'b01;
        q_ord.push_back(1'b1);
        do_write(4'd8, 32'h300, 8'd0, 3'd2, 2'b01, 1'b1, -1, '{32'h300, 32'h0, 32'h0, 32'h0}, 1'b1, 2'b01);
        wait_done();
        q_ord.push_back(1'b1);
        do_write(4'd9, 32'h300, 8'd1, 3'd2, 2'b01, 1'b1, -1, '{32'h300, 32'h304, 32'h0, 32'h0}, 1'b0, 2'b00);
        wait_done();
        b_resp_k = 2'b11;
        q_ord.push_back(1'b1);
        do_write(4'd10, 32'h310, 8'd1, 3'd2, 2'b01, 1'b0, -1, '{32'h310, 32'h314, 32'h0, 32'h0}, 1'b0, 2'b11);
        wait_done();
        b_resp_k = 2'b00;

        // Slave-side back-pressure stalls the replay.
        s_rready = 1'b0;
        q_ord.push_back(1'b0);
        do_read(4'd11, 32'h700, 8'd1, 3'd2, 2'b01, '{32'h700, 32'h704, 32'h0, 32'h0}, 1'b1);
        begin
            bit seen = 1'b0;
            for (int t = 0; t < 50 && !seen; t++) begin
                @(negedge clk_i);
                seen = s_rvalid;
            end
            chk("stall_rvalid_seen", 80'(seen), 80'(1));
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            chk("stall_rvalid_held", 80'(s_rvalid), 80'(1));
            chk("stall_no_arvalid", 80'(m_arvalid), 80'(0));
        end
        @(posedge clk_i); #1;
        s_rready = 1'b1;
        wait_done();

        // Reset while waiting for read data abandons the burst.
        hold_r = 1'b1;
        q_ord.push_back(1'b0);
        do_read(4'd12, 32'h800, 8'd0, 3'd2, 2'b01, '{32'h800, 32'h0, 32'h0, 32'h0}, 1'b0);
        wait_done();
        @(negedge clk_i);
        chk("rdata_wait_rready", 80'(m_rready), 80'(1));
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        chk_reset_outputs("mid_burst_reset");
        @(posedge clk_i); #1;
        rst_i  = 1'b0;
        hold_r = 1'b0;

        q_ord.push_back(1'b0);
        do_read(4'd13, 32'h900, 8'd0, 3'd2, 2'b01, '{32'h900, 32'h0, 32'h0, 32'h0}, 1'b1);
        wait_done();
        repeat (3) @(posedge clk_i);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
